// File: rtl/div_issue_ctrl.sv
// -----------------------------------------------------------------------------
// div_issue_ctrl
//   Sequences the shared 32-bit radix-4 divider core for DIV/DIVU in EX.
//   It captures the operands, issues a one-cycle start pulse, stalls IF..EX
//   until the result returns, and writes {remainder, quotient} to HI/LO.
//   A zero divisor can bypass the core. A pipeline flush cancels the
//   operation. A watchdog aborts the core if no result arrives.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   div_req           EX holds a DIV/DIVU (held until stall drops)
//   div_signed        1 = DIV, 0 = DIVU
//   op_a, op_b        dividend, divisor
//   flush             cancel of the EX instruction
//   stall             freeze IF..EX (combinational)
//   hilo_we           one-cycle HI/LO write strobe
//   hi_out, lo_out    remainder, quotient
//   timeout_err       one-cycle pulse on watchdog abort
//   core_start        start pulse to the divider core
//   core_sign         signed-mode select to the core
//   core_a, core_b    operands to the core (stable until back in IDLE)
//   core_rst          synchronous abort to the core
//   core_result       {remainder, quotient} from the core
//   core_ready        one-cycle result-valid pulse from the core
//   core_busy         core running
// -----------------------------------------------------------------------------
module div_issue_ctrl #(
    parameter bit DIV0_BYPASS = 1'b1,
    parameter int TIMEOUT     = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_req,
    input  logic        div_signed,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        stall,
    output logic        hilo_we,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        timeout_err,
    output logic        core_start,
    output logic        core_sign,
    output logic [31:0] core_a,
    output logic [31:0] core_b,
    output logic        core_rst,
    input  logic [63:0] core_result,
    input  logic        core_ready,
    input  logic        core_busy
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [31:0]     r_a;
    logic [31:0]     r_b;
    logic            r_sign;
    logic [31:0]     r_hi;
    logic [31:0]     r_lo;
    logic [CW-1:0]   r_cnt;
    logic            r_timed_out;   // DONE was reached by watchdog abort

    logic            w_accept;
    logic            w_bypass;
    logic            w_load_result;
    logic            w_timeout;

    assign core_a    = r_a;
    assign core_b    = r_b;
    assign core_sign = r_sign;
    assign hi_out    = r_hi;
    assign lo_out    = r_lo;

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_accept      = 1'b0;
        w_bypass      = 1'b0;
        w_load_result = 1'b0;
        w_timeout     = 1'b0;
        stall         = 1'b0;
        hilo_we       = 1'b0;
        timeout_err   = 1'b0;
        core_start    = 1'b0;
        core_rst      = rst;

        case (r_state)
            S_IDLE: begin
                // Stall is raised even while waiting for a busy core, so
                // the instruction stays put until it can be accepted.
                stall = div_req && !flush;
                if (div_req && !flush && !core_busy) begin
                    w_accept = 1'b1;
                    if (DIV0_BYPASS && (op_b == 32'd0)) begin
                        w_bypass     = 1'b1;
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                stall = div_req && !flush;
                if (flush) begin
                    core_rst     = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    core_start   = 1'b1;
                    w_state_next = S_WAIT;
                end
            end

            S_WAIT: begin
                stall = div_req && !flush;
                // Priority: flush over a result, and a result over the
                // watchdog when both land in the same cycle.
                if (flush) begin
                    core_rst     = 1'b1;
                    w_state_next = S_IDLE;
                end else if (core_ready) begin
                    w_load_result = 1'b1;
                    w_state_next  = S_DONE;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_timeout    = 1'b1;
                    core_rst     = 1'b1;
                    timeout_err  = 1'b1;
                    w_state_next = S_DONE;
                end
            end

            S_DONE: begin
                // stall stays low: the EX instruction advances this cycle.
                if (flush) begin
                    core_rst = 1'b1;
                end else begin
                    hilo_we = !r_timed_out;
                end
                w_state_next = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Reset forces every pipeline-facing output quiet; only the core
        // abort stays asserted.
        if (rst) begin
            stall       = 1'b0;
            hilo_we     = 1'b0;
            timeout_err = 1'b0;
            core_start  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= 32'd0;
            r_b         <= 32'd0;
            r_sign      <= 1'b0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
            r_cnt       <= '0;
            r_timed_out <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_timed_out <= w_timeout;

            if (w_accept) begin
                r_a    <= op_a;
                r_b    <= op_b;
                r_sign <= div_signed;
            end

            if (w_bypass) begin
                r_hi <= op_a;
                r_lo <= 32'hFFFF_FFFF;
            end else if (w_load_result) begin
                r_hi <= core_result[63:32];
                r_lo <= core_result[31:0];
            end

            // Watchdog: cleared while issuing, counts every WAIT cycle.
            if (r_state == S_ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
